fma16_norm_round: RTL and testbench
===================================

# fma16_norm_round

Elastic two-stage normalize/round/pack back end for the half-precision FMA. It consumes the aligned sum (`ss`, `se`, `sm`, `m_shift`) produced by the align-and-sum stage, together with any special-case override. It left-normalizes the sum, rounds to IEEE binary16 under a selectable rounding mode, and emits a packed 16-bit result plus exception flags. A valid/ready handshake on both sides lets a multi-cycle or stalled consumer backpressure the FMA datapath.

## Interface
- `VEC_SIZE`, 34, width of `sm`; the leading-one reference position is bit `VEC_SIZE-1`; legal range is 22 and up.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `ss`  in  1  sum sign
- `se`  in  7  biased exponent of a leading one at `sm[VEC_SIZE-1]`, two's-complement signed
- `sm`  in  `VEC_SIZE`  unsigned sum magnitude
- `m_shift`  in  8  leading-zero count of `sm`; don't-care when `sm==0`
- `roundmode`  in  2  00 RZ, 01 RNE, 10 RM (toward −∞), 11 RP (toward +∞)
- `special_valid`  in  1  override beat with `special_res`/`special_flags` (NaN, Inf, invalid paths)
- `special_res`  in  16  override result
- `special_flags`  in  4  override flags
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `result`  out  16  binary16 result
- `flags`  out  4  {invalid, overflow, underflow, inexact}

## Operation
- **Stage 1 (S1, registered on accept).**
  - Normalizes: `nm = sm << m_shift`.
  - Computes `re = se − m_shift` as a 9-bit signed value.
  - Captures `roundmode`, the `special_*` inputs and `ss`.
- **Stage 2 (S2 = output register).**
  - Fields taken from `nm`: fraction `nm[VEC_SIZE-2:VEC_SIZE-11]`, guard `nm[VEC_SIZE-12]`, sticky = OR of the remaining low bits.
  - RNE: increment if guard & (sticky | lsb).
  - RZ: never increment.
  - RP: increment if ¬sign & (guard | sticky).
  - RM: increment if sign & (guard | sticky).
  - A mantissa carry-out sets the fraction to 0 and does `re+1`.
  - Inexact = guard | sticky.
- **Zero.** `sm==0` → result `{ss,15'h0}`, flags 0.
- **Overflow.** Post-round `re ≥ 31` sets overflow and inexact.
  - RNE → ±Inf (0x7C00 / 0xFC00).
  - RZ → ±0x7BFF.
  - RP → +Inf or −0x7BFF (i.e. 0xFBFF).
  - RM → +0x7BFF or −Inf.
- **Underflow.** Pre-round `re ≤ 0` with `sm≠0` is handled per Configuration.
- **Special override.** `special_valid` passes `special_res`/`special_flags` through unchanged; the rounding logic is ignored for that beat.
- **Handshake.**
  - A beat is accepted on `in_valid & in_ready`.
  - A beat is consumed on `out_valid & out_ready`.
  - S1 advances when S2 is empty or being consumed.
  - `in_ready = ~s1_valid | s1_advance`.
- **Output stability.** While `out_valid & ~out_ready`, `result`/`flags` are held stable. `in_valid` may drop without penalty.
- **Combinational paths.** No path from `in_valid` to `in_ready`. `out_ready` reaches `in_ready` combinationally through the advance chain.

## Timing
- **Reset.**
  - Assertion of `reset_n` low immediately (asynchronously) clears both stage valids.
  - Reset values: `result=0`, `flags=0`, `out_valid=0`.
  - `in_ready=1` from the first cycle after deassertion.
  - In-flight beats are discarded, not completed.
- **Latency.** A beat accepted at edge *t* presents `out_valid` after edge *t+1* when unstalled. Total latency is 2 registers; throughput is 1 beat/cycle.
- **Capacity.** 2 beats (S1 + S2). With `out_ready` low, the third beat sees `in_ready=0`.
- **Simultaneous events.** Consume and accept in the same cycle both occur with no bubble.

## Configuration
- **Macro:** `FMA16_SUBNORM_EN`.
- **Defined (gradual underflow).**
  - `nm` is right-shifted by `1−re`, saturated at 12, with shifted-out bits ORed into sticky.
  - Rounding then proceeds with exponent field 0.
  - A round carry into bit 10 yields the minimum normal (exp 1).
  - Underflow flag = tiny & inexact.
- **Undefined (flush-to-zero).**
  - Any `re ≤ 0` with `sm≠0` gives `{ss,15'h0}` with underflow | inexact.
  - No denormal shifter is built.

## Test plan
- **Normal, exact:** `sm=34'h2_0000_0000`, `se=15`, `m_shift=0`, RNE → `result=0x3C00`, `flags=0`, `out_valid` 2 edges after accept.
- **Tie rounding:** `sm=34'h2_0040_0000`, `se=15`.
  - RNE → 0x3C00, flags 0001.
  - RP → 0x3C01.
  - RZ → 0x3C00.
- **Normalization:** `sm=34'h0_8000_0000`, `se=17`, `m_shift=2` → 0x3C00. With `sm=0` and `ss=1` → 0x8000, flags 0.
- **Overflow:** `sm=34'h2_0000_0000`, `se=31`, `ss=0`.
  - RNE → 0x7C00, flags 0101.
  - RZ → 0x7BFF.
  - With `ss=1` and RP → 0xFBFF.
- **Underflow:** `se=0`, `sm=34'h2_0000_0000`.
  - FTZ build → 0x0000, flags 0011.
  - `FMA16_SUBNORM_EN` build → 0x0200, flags 0000.
- **Backpressure and reset:** hold `out_ready=0` and offer 3 beats → `in_ready=0` on the 3rd. Release → results in order, with `result` stable while stalled. Pulse `reset_n` low mid-stall → `out_valid` drops immediately, no stale beat after release.

Source files
------------

// File: rtl/fma16_norm_round.sv
// Two-stage elastic normalize/round/pack back end for the binary16 FMA.
// Define FMA16_SUBNORM_EN to build gradual underflow; otherwise tiny results flush to zero.
module fma16_norm_round #(
  parameter int VEC_SIZE = 34
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                ss,
  input  logic [6:0]          se,
  input  logic [VEC_SIZE-1:0] sm,
  input  logic [7:0]          m_shift,
  input  logic [1:0]          roundmode,
  input  logic                special_valid,
  input  logic [15:0]         special_res,
  input  logic [3:0]          special_flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         result,
  output logic [3:0]          flags
);

  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RM  = 2'b10,
    RM_RP  = 2'b11
  } round_mode_e;

  logic                s1_valid;
  logic                s2_valid;
  logic                s2_free;
  logic                accept;
  logic                s2_load;
  logic [VEC_SIZE-1:0] nm_in;

  logic [VEC_SIZE-1:0] s1_nm;
  logic signed [8:0]   s1_re;
  round_mode_e         s1_rm;
  logic                s1_ss;
  logic                s1_special;
  logic [15:0]         s1_special_res;
  logic [3:0]          s1_special_flags;

  assign s2_free   = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_free;
  assign accept    = in_valid & in_ready;
  assign s2_load   = s1_valid & s2_free;
  assign out_valid = s2_valid;
  assign nm_in     = sm << m_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;
      if (s2_free)
        s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_nm            <= nm_in;
      s1_re            <= $signed({{2{se[6]}}, se}) - $signed({1'b0, m_shift});
      s1_rm            <= round_mode_e'(roundmode);
      s1_ss            <= ss;
      s1_special       <= special_valid;
      s1_special_res   <= special_res;
      s1_special_flags <= special_flags;
    end
  end

  // m_shift is the leading-zero count, so the hidden bit is set exactly when sm was nonzero.
  logic                s1_zero;
  logic                tiny;
  logic [VEC_SIZE-2:0] rnd_nm;
  logic                lost;

  assign s1_zero = ~s1_nm[VEC_SIZE-1];
  assign tiny    = (s1_re <= 9'sd0);

`ifdef FMA16_SUBNORM_EN
  logic signed [9:0] dn_amt10;
  logic [3:0]        dn_amt;

  assign dn_amt10 = 10'sd1 - $signed({s1_re[8], s1_re});

  always_comb begin
    dn_amt = 4'd0;
    if (tiny)
      dn_amt = (dn_amt10 > 10'sd12) ? 4'd12 : dn_amt10[3:0];
  end

  // The hidden bit drops into the fraction field; bits shifted past bit 0 feed sticky.
  assign rnd_nm = tiny ? (s1_nm[VEC_SIZE-1:1] >> (dn_amt - 4'd1)) : s1_nm[VEC_SIZE-2:0];
  assign lost   = |(s1_nm & ~({VEC_SIZE{1'b1}} << dn_amt));
`else
  assign rnd_nm = s1_nm[VEC_SIZE-2:0];
  assign lost   = 1'b0;
`endif

  logic [9:0]        frac;
  logic              guard;
  logic              sticky;
  logic              inexact;
  logic              inc;
  logic [10:0]       frac_sum;
  logic signed [9:0] re_post;
  logic              ovf;

  assign frac     = rnd_nm[VEC_SIZE-2 -: 10];
  assign guard    = rnd_nm[VEC_SIZE-12];
  assign sticky   = (|rnd_nm[VEC_SIZE-13:0]) | lost;
  assign inexact  = guard | sticky;
  assign frac_sum = {1'b0, frac} + {10'd0, inc};
  assign re_post  = $signed({s1_re[8], s1_re}) + $signed({9'd0, frac_sum[10]});
  assign ovf      = ~tiny & (re_post >= 10'sd31);

  always_comb begin
    inc = 1'b0;
    case (s1_rm)
      RM_RNE:  inc = guard & (sticky | frac[0]);
      RM_RP:   inc = ~s1_ss & inexact;
      RM_RM:   inc = s1_ss & inexact;
      default: inc = 1'b0;
    endcase
  end

  logic [15:0] nxt_result;
  logic [3:0]  nxt_flags;

  always_comb begin
    nxt_result = {s1_ss, re_post[4:0], frac_sum[9:0]};
    nxt_flags  = {3'b000, inexact};
    if (s1_special) begin
      nxt_result = s1_special_res;
      nxt_flags  = s1_special_flags;
    end else if (s1_zero) begin
      nxt_result = {s1_ss, 15'h0000};
      nxt_flags  = 4'b0000;
    end else if (tiny) begin
`ifdef FMA16_SUBNORM_EN
      // A carry out of the fraction lands in the exponent LSB, giving the minimum normal.
      nxt_result = {s1_ss, 4'b0000, frac_sum};
      nxt_flags  = {2'b00, inexact, inexact};
`else
      nxt_result = {s1_ss, 15'h0000};
      nxt_flags  = 4'b0011;
`endif
    end else if (ovf) begin
      nxt_flags = 4'b0101;
      case (s1_rm)
        RM_RNE:  nxt_result = {s1_ss, 15'h7C00};
        RM_RP:   nxt_result = s1_ss ? 16'hFBFF : 16'h7C00;
        RM_RM:   nxt_result = s1_ss ? 16'hFC00 : 16'h7BFF;
        default: nxt_result = {s1_ss, 15'h7BFF};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= 16'h0000;
      flags  <= 4'b0000;
    end else if (s2_load) begin
      result <= nxt_result;
      flags  <= nxt_flags;
    end
  end

endmodule

// File: tb/tb_fma16_norm_round.sv
// Directed self-checking bench for fma16_norm_round: rounding modes, range limits,
// special override, backpressure and asynchronous reset.
module tb_fma16_norm_round;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        ss;
  logic [6:0]  se;
  logic [33:0] sm;
  logic [7:0]  m_shift;
  logic [1:0]  roundmode;
  logic        special_valid;
  logic [15:0] special_res;
  logic [3:0]  special_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int tests;
  int failures;

  fma16_norm_round dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ss            (ss),
    .se            (se),
    .sm            (sm),
    .m_shift       (m_shift),
    .roundmode     (roundmode),
    .special_valid (special_valid),
    .special_res   (special_res),
    .special_flags (special_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .flags         (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [6:0] e, input logic [33:0] m,
                                input logic [7:0] sh, input logic [1:0] rm);
    ss            = s;
    se            = e;
    sm            = m;
    m_shift       = sh;
    roundmode     = rm;
    special_valid = 1'b0;
    special_res   = 16'h0000;
    special_flags = 4'b0000;
  endtask

  // One beat through an unstalled pipe: accepted at the first edge, visible after the second.
  task automatic run_vector(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_flags);
    in_valid = 1'b1;
    check_output({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_output({tag, "_lat_s1"}, out_valid, 1'b0);
    step();
    check_output({tag, "_valid"}, out_valid, 1'b1);
    check_output({tag, "_result"}, result, exp_res);
    check_output({tag, "_flags"}, flags, exp_flags);
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 7'd0, 34'h0, 8'd0, 2'b01);

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_result", result, 16'h0000);
    check_output("rst_flags", flags, 4'b0000);
    reset_n = 1'b1;
    step();
    check_output("rst_in_ready", in_ready, 1'b1);

    apply_stimulus(1'b0, 7'd15, 34'h2_0000_0000, 8'd0, 2'b01);
    run_vector("exact_rne", 16'h3C00, 4'b0000);
    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0000, 8'd0, 2'b01);
    run_vector("tie_rne", 16'h3C00, 4'b0001);
    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0000, 8'd0, 2'b11);
    run_vector("tie_rp", 16'h3C01, 4'b0001);
    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0000, 8'd0, 2'b00);
    run_vector("tie_rz", 16'h3C00, 4'b0001);
    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0001, 8'd0, 2'b01);
    run_vector("above_half_rne", 16'h3C01, 4'b0001);
    apply_stimulus(1'b0, 7'd15, 34'h3_FFC0_0000, 8'd0, 2'b01);
    run_vector("carry_rne", 16'h4000, 4'b0001);
    apply_stimulus(1'b1, 7'd15, 34'h2_0000_0001, 8'd0, 2'b10);
    run_vector("sticky_rm_neg", 16'hBC01, 4'b0001);
    apply_stimulus(1'b0, 7'd17, 34'h0_8000_0000, 8'd2, 2'b01);
    run_vector("normalize", 16'h3C00, 4'b0000);
    apply_stimulus(1'b1, 7'd15, 34'h0, 8'd0, 2'b01);
    run_vector("zero_neg", 16'h8000, 4'b0000);

    apply_stimulus(1'b0, 7'd31, 34'h2_0000_0000, 8'd0, 2'b01);
    run_vector("ovf_rne", 16'h7C00, 4'b0101);
    apply_stimulus(1'b0, 7'd31, 34'h2_0000_0000, 8'd0, 2'b00);
    run_vector("ovf_rz", 16'h7BFF, 4'b0101);
    apply_stimulus(1'b1, 7'd31, 34'h2_0000_0000, 8'd0, 2'b11);
    run_vector("ovf_rp_neg", 16'hFBFF, 4'b0101);
    apply_stimulus(1'b1, 7'd31, 34'h2_0000_0000, 8'd0, 2'b10);
    run_vector("ovf_rm_neg", 16'hFC00, 4'b0101);
    apply_stimulus(1'b0, 7'd31, 34'h2_0000_0000, 8'd0, 2'b10);
    run_vector("ovf_rm_pos", 16'h7BFF, 4'b0101);

    apply_stimulus(1'b0, 7'd0, 34'h2_0000_0000, 8'd0, 2'b01);
`ifdef FMA16_SUBNORM_EN
    run_vector("underflow", 16'h0200, 4'b0000);
`else
    run_vector("underflow", 16'h0000, 4'b0011);
`endif

    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0000, 8'd0, 2'b11);
    special_valid = 1'b1;
    special_res   = 16'h7E00;
    special_flags = 4'b1000;
    run_vector("special", 16'h7E00, 4'b1000);

    // Backpressure: two beats fill the pipe, the third is refused until the consumer returns.
    step();
    out_ready = 1'b0;
    apply_stimulus(1'b0, 7'd15, 34'h2_0000_0000, 8'd0, 2'b01);
    in_valid = 1'b1;
    step();
    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0000, 8'd0, 2'b11);
    step();
    check_output("bp_a_valid", out_valid, 1'b1);
    check_output("bp_a_result", result, 16'h3C00);
    apply_stimulus(1'b1, 7'd15, 34'h0, 8'd0, 2'b01);
    #1;
    check_output("bp_full_in_ready", in_ready, 1'b0);
    step();
    check_output("bp_stall_in_ready", in_ready, 1'b0);
    check_output("bp_stall_result1", result, 16'h3C00);
    step();
    check_output("bp_stall_result2", result, 16'h3C00);
    check_output("bp_stall_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check_output("bp_release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_output("bp_b_result", result, 16'h3C01);
    check_output("bp_b_flags", flags, 4'b0001);
    step();
    check_output("bp_c_result", result, 16'h8000);
    check_output("bp_c_valid", out_valid, 1'b1);
    step();
    check_output("bp_drained", out_valid, 1'b0);

    // Asynchronous reset in the middle of a stall discards both held beats.
    out_ready = 1'b0;
    apply_stimulus(1'b0, 7'd15, 34'h2_0040_0000, 8'd0, 2'b11);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check_output("rs_pre_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rs_async_valid", out_valid, 1'b0);
    check_output("rs_async_result", result, 16'h0000);
    #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    check_output("rs_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_output("rs_no_stale", out_valid, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
